blake2s_io_host: RTL and testbench

Host-side driver for the Blake2s chip pin protocol. It converts a configuration request and an upstream byte stream into valid/cmd/data pin traffic, and it collects the nn-byte digest returned on the hash pins. It is the transmitter matching the chip's io_intf receiver, and it is used in the FPGA test harness and the cocotb reference host.

---
 rtl/blake2s_io_host.sv | 220 ++++++++++++++++++++++
 tb/tb_blake2s_io_host.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2s_io_host.sv
// Host-side pin driver for the Blake2s chip: CONF bytes, 64-byte blocks, digest collection.
// All pin/upstream outputs registered (1 cycle); upstream stalls become valid_o gaps, chip paced by ready_v_i.
module blake2s_io_host #(
  parameter int LL_W = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            start_i,
  input  logic [5:0]      kk_i,
  input  logic [5:0]      nn_i,
  input  logic [LL_W-1:0] ll_i,
  input  logic            m_v_i,
  input  logic [7:0]      m_i,
  output logic            m_ready_o,
  output logic            valid_o,
  output logic [1:0]      cmd_o,
  output logic [7:0]      data_o,
  input  logic            ready_v_i,
  input  logic            hash_v_i,
  input  logic [7:0]      hash_i,
  output logic            h_v_o,
  output logic [7:0]      h_o,
  output logic            h_last_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int BW = LL_W - 5;
  localparam logic [BW-1:0] ONE_BLK = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DATA  = 2'd2;
  localparam logic [1:0] CMD_LAST  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_WAIT_RDY, S_BLOCK, S_WAIT_HASH, S_HASH
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      kk_q, kk_d, nn_q, nn_d;
  logic [LL_W-1:0] ll_q, ll_d, cons_q, cons_d;
  logic [BW-1:0]   nblk_q, nblk_d, blk_q, blk_d;
  logic [5:0]      idx_q, idx_d, hcnt_q, hcnt_d;
  logic            wfirst_q, wfirst_d;
  logic            busy_q, busy_d, err_q, err_d;
  logic            valid_q, valid_d, m_ready_q, m_ready_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [7:0]      data_q, data_d, h_q, h_d;
  logic            h_v_q, h_v_d, h_last_q, h_last_d;

  logic [63:0]     ll64;
  logic [BW-1:0]   ll_blks, nblk_calc;
  logic            key_blk, key_blk_d;
  logic [1:0]      blk_cmd;

  always_comb begin
    state_d   = state_q;
    kk_d      = kk_q;
    nn_d      = nn_q;
    ll_d      = ll_q;
    cons_d    = cons_q;
    nblk_d    = nblk_q;
    blk_d     = blk_q;
    idx_d     = idx_q;
    hcnt_d    = hcnt_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    valid_d   = 1'b0;
    cmd_d     = 2'd0;
    data_d    = 8'd0;
    h_v_d     = 1'b0;
    h_d       = 8'd0;
    h_last_d  = 1'b0;

    ll64 = '0;
    ll64[LL_W-1:0] = ll_q;
    // ceil(ll/64) from the upper bits plus a remainder flag cannot overflow BW bits
    ll_blks   = {1'b0, ll_i[LL_W-1:6]} + {{(BW-1){1'b0}}, |ll_i[5:0]};
    nblk_calc = ll_blks + {{(BW-1){1'b0}}, (kk_i != 6'd0)};
    if (nblk_calc == '0) nblk_calc = ONE_BLK;

    key_blk = (kk_q != 6'd0) && (blk_q == ONE_BLK);
    if (blk_q == nblk_q)       blk_cmd = CMD_LAST;
    else if (blk_q == ONE_BLK) blk_cmd = CMD_START;
    else                       blk_cmd = CMD_DATA;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (kk_i <= 6'd32 && nn_i != 6'd0 && nn_i <= 6'd32) begin
            kk_d    = kk_i;
            nn_d    = nn_i;
            ll_d    = ll_i;
            nblk_d  = nblk_calc;
            blk_d   = ONE_BLK;
            cons_d  = '0;
            idx_d   = 6'd0;
            hcnt_d  = 6'd0;
            busy_d  = 1'b1;
            state_d = S_CONF;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CONF: begin
        valid_d = 1'b1;
        cmd_d   = CMD_CONF;
        if (idx_q == 6'd0)      data_d = {2'b00, kk_q};
        else if (idx_q == 6'd1) data_d = {2'b00, nn_q};
        else begin
          for (int k = 0; k < 8; k++)
            if (idx_q == 6'(k + 2)) data_d = ll64[8*k +: 8];
        end
        if (idx_q == 6'd9) begin
          idx_d   = 6'd0;
          state_d = S_WAIT_RDY;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_WAIT_RDY: begin
        // The previous block's final byte is still on the pins during the first
        // cycle here, so a ready_v_i seen then may be stale.
        if (!wfirst_q && ready_v_i) state_d = S_BLOCK;
      end
      S_BLOCK: begin
        if (!(m_ready_q && !m_v_i)) begin
          valid_d = 1'b1;
          cmd_d   = blk_cmd;
          data_d  = m_ready_q ? m_i : 8'd0;
          if (m_ready_q && !key_blk) cons_d = cons_q + 1'b1;
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            if (blk_q == nblk_q) begin
              state_d = S_WAIT_HASH;
            end else begin
              blk_d   = blk_q + ONE_BLK;
              state_d = S_WAIT_RDY;
            end
          end
        end
      end
      S_WAIT_HASH, S_HASH: begin
        if (hash_v_i) begin
          h_v_d   = 1'b1;
          h_d     = hash_i;
          hcnt_d  = hcnt_q + 6'd1;
          state_d = S_HASH;
          if (hcnt_q + 6'd1 == nn_q) begin
            h_last_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    wfirst_d  = (state_d == S_WAIT_RDY) && (state_q != S_WAIT_RDY);
    // Ready is asserted for the cycle in which the byte at idx_d must come from upstream.
    key_blk_d = (kk_q != 6'd0) && (blk_d == ONE_BLK);
    m_ready_d = (state_d == S_BLOCK) && (key_blk_d ? (idx_d < kk_q) : (cons_d < ll_q));
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      kk_q      <= '0;
      nn_q      <= '0;
      ll_q      <= '0;
      cons_q    <= '0;
      nblk_q    <= '0;
      blk_q     <= '0;
      idx_q     <= '0;
      hcnt_q    <= '0;
      wfirst_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      cmd_q     <= '0;
      data_q    <= '0;
      m_ready_q <= 1'b0;
      h_v_q     <= 1'b0;
      h_q       <= '0;
      h_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      kk_q      <= kk_d;
      nn_q      <= nn_d;
      ll_q      <= ll_d;
      cons_q    <= cons_d;
      nblk_q    <= nblk_d;
      blk_q     <= blk_d;
      idx_q     <= idx_d;
      hcnt_q    <= hcnt_d;
      wfirst_q  <= wfirst_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      m_ready_q <= m_ready_d;
      h_v_q     <= h_v_d;
      h_q       <= h_d;
      h_last_q  <= h_last_d;
    end
  end

  assign m_ready_o = m_ready_q;
  assign valid_o   = valid_q;
  assign cmd_o     = cmd_q;
  assign data_o    = data_q;
  assign h_v_o     = h_v_q;
  assign h_o       = h_q;
  assign h_last_o  = h_last_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_blake2s_io_host.sv
// Scoreboard bench for blake2s_io_host: reference pin/digest streams built from message-level rules.
module tb_blake2s_io_host;
  localparam int LL_W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            nreset, start_i, m_v_i, m_ready_o, valid_o, ready_v_i;
  logic            hash_v_i, h_v_o, h_last_o, busy_o, err_o;
  logic [5:0]      kk_i, nn_i;
  logic [LL_W-1:0] ll_i;
  logic [7:0]      m_i, data_o, hash_i, h_o;
  logic [1:0]      cmd_o;

  blake2s_io_host #(.LL_W(LL_W)) dut (
    .clk(clk), .nreset(nreset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
    .ll_i(ll_i), .m_v_i(m_v_i), .m_i(m_i), .m_ready_o(m_ready_o),
    .valid_o(valid_o), .cmd_o(cmd_o), .data_o(data_o), .ready_v_i(ready_v_i),
    .hash_v_i(hash_v_i), .hash_i(hash_i), .h_v_o(h_v_o), .h_o(h_o),
    .h_last_o(h_last_o), .busy_o(busy_o), .err_o(err_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] up_q[$];
  logic [9:0] exp_pin[$];
  logic [8:0] exp_h[$];
  logic [7:0] key_b[$];
  logic [7:0] msg_b[$];
  int gap_pct = 0;
  int cur_nn = 1;
  int cur_extra = 0;
  int bcnt = 0;
  bit rdy_ok = 1'b1;
  bit hash_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  // Upstream source: presents up_q head, optionally withholding it to create gaps.
  initial begin : up_drv
    bit acc;
    m_v_i = 1'b0;
    m_i = 8'd0;
    forever begin
      @(posedge clk);
      acc = m_v_i && m_ready_o;
      @(negedge clk);
      if (acc && up_q.size() > 0) void'(up_q.pop_front());
      if (up_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        m_v_i = 1'b1;
        m_i = up_q[0];
      end else begin
        m_v_i = 1'b0;
        m_i = 8'($urandom);
      end
    end
  end

  // Chip model plus monitor: checks pins and digest, paces blocks, returns digest bytes.
  initial begin : chip
    int rdy_dly, hash_dly, hash_left, hash_sent;
    logic [9:0] e;
    logic [8:0] eh;
    logic [7:0] hb;
    rdy_dly = 0; hash_dly = 0; hash_left = 0; hash_sent = 0;
    ready_v_i = 1'b1;
    hash_v_i = 1'b0;
    hash_i = 8'd0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        bcnt = 0; rdy_dly = 0; hash_dly = 0; hash_left = 0;
        ready_v_i = 1'b1; hash_v_i = 1'b0; rdy_ok = 1'b1;
        continue;
      end
      if (valid_o) begin
        if (exp_pin.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL pin_unexpected: got cmd %0d data 0x%02h, expected no pin traffic at %0t",
                   cmd_o, data_o, $time);
        end else begin
          e = exp_pin.pop_front();
          chk("pin_cmd_data", {cmd_o, data_o}, e);
        end
      end
      if (h_v_o) begin
        if (exp_h.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL digest_unexpected: got 0x%02h last %0d, expected no digest byte at %0t",
                   h_o, h_last_o, $time);
        end else begin
          eh = exp_h.pop_front();
          chk("digest_last_data", {h_last_o, h_o}, eh);
        end
      end
      if (rdy_dly > 0) begin
        rdy_dly--;
        if (rdy_dly == 0) begin
          ready_v_i = 1'b1;
          rdy_ok = 1'b1;
        end
      end
      if (valid_o && cmd_o != 2'd0) begin
        if (bcnt == 0) chk("block_after_ready", rdy_ok, 1);
        bcnt++;
        if (bcnt == 64) begin
          bcnt = 0;
          ready_v_i = 1'b0;
          rdy_ok = 1'b0;
          rdy_dly = $urandom_range(3, 7);
          if (cmd_o == 2'd3) hash_dly = $urandom_range(2, 9);
        end
      end
      hash_v_i = 1'b0;
      if (hash_dly > 0) begin
        hash_dly--;
        if (hash_dly == 0) begin
          hash_left = cur_nn + cur_extra;
          hash_sent = 0;
        end
      end else if (hash_left > 0 && $urandom_range(99) < 70) begin
        hb = 8'($urandom);
        hash_v_i = 1'b1;
        hash_i = hb;
        if (hash_sent < cur_nn) exp_h.push_back({hash_sent == cur_nn - 1, hb});
        hash_sent++;
        hash_left--;
        if (hash_left == 0) hash_done = 1'b1;
      end
    end
  end

  task automatic prep(input int kk, input int ll);
    key_b.delete();
    msg_b.delete();
    for (int i = 0; i < kk; i++) key_b.push_back(8'($urandom));
    for (int i = 0; i < ll; i++) msg_b.push_back(8'($urandom));
  endtask

  task automatic build_conf(input int kk, input int nn, input logic [63:0] ll);
    exp_pin.push_back({2'd0, 8'(kk)});
    exp_pin.push_back({2'd0, 8'(nn)});
    for (int i = 0; i < 8; i++) exp_pin.push_back({2'd0, 8'(ll >> (8 * i))});
  endtask

  // Key padded to one block, message padded to whole blocks, at least one block overall.
  task automatic build_model(input int kk, input int nn, input int ll);
    logic [7:0] stream[$];
    int nb;
    logic [1:0] c;
    build_conf(kk, nn, 64'(ll));
    if (kk > 0)
      for (int i = 0; i < 64; i++) stream.push_back(i < kk ? key_b[i] : 8'd0);
    for (int i = 0; i < ((ll + 63) / 64) * 64; i++) stream.push_back(i < ll ? msg_b[i] : 8'd0);
    if (stream.size() == 0)
      for (int i = 0; i < 64; i++) stream.push_back(8'd0);
    nb = stream.size() / 64;
    for (int j = 0; j < nb; j++) begin
      c = (j == nb - 1) ? 2'd3 : ((j == 0) ? 2'd1 : 2'd2);
      for (int i = 0; i < 64; i++) exp_pin.push_back({c, stream[j * 64 + i]});
    end
    for (int i = 0; i < kk; i++) up_q.push_back(key_b[i]);
    for (int i = 0; i < ll; i++) up_q.push_back(msg_b[i]);
  endtask

  task automatic run_msg(input int kk, input int nn, input int ll, input int gap,
                         input int extra, input bit poke);
    int cyc;
    gap_pct = gap;
    cur_nn = nn;
    cur_extra = extra;
    hash_done = 1'b0;
    build_model(kk, nn, ll);
    @(negedge clk);
    start_i = 1'b1; kk_i = 6'(kk); nn_i = 6'(nn); ll_i = 64'(ll);
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    chk("no_err_valid_cfg", err_o, 0);
    if (poke) begin
      repeat (30) @(negedge clk);
      start_i = 1'b1; kk_i = 6'd5; nn_i = 6'd5; ll_i = 64'd9;
      @(negedge clk);
      start_i = 1'b0;
      chk("busy_start_ignored_err", err_o, 0);
    end
    cyc = 0;
    while (!(hash_done && !busy_o) && cyc < 6000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 6000) begin
      n_chk++; n_fail++;
      $display("FAIL run_timeout: got busy %0d hash_done %0d, expected completion within 6000 cycles",
               busy_o, hash_done);
      summary();
    end
    repeat (4) @(negedge clk);
    chk("pins_drained", exp_pin.size(), 0);
    chk("digest_drained", exp_h.size(), 0);
    chk("upstream_drained", up_q.size(), 0);
    chk("busy_end", busy_o, 0);
  endtask

  task automatic bad_cfg(input int kk, input int nn);
    @(negedge clk);
    start_i = 1'b1; kk_i = 6'(kk); nn_i = 6'(nn); ll_i = 64'($urandom_range(200));
    @(negedge clk);
    start_i = 1'b0;
    chk("err_pulse", err_o, 1);
    chk("err_busy_low", busy_o, 0);
    @(negedge clk);
    chk("err_one_cycle", err_o, 0);
    repeat (12) @(negedge clk);
    chk("err_busy_stays_low", busy_o, 0);
  endtask

  task automatic do_reset();
    #2 nreset = 1'b0;
    #1 chk("async_reset_outputs",
           {valid_o, cmd_o, data_o, m_ready_o, h_v_o, h_o, h_last_o, busy_o, err_o}, 0);
    exp_pin.delete();
    exp_h.delete();
    up_q.delete();
    repeat (3) @(negedge clk);
    chk("reset_no_pins", valid_o, 0);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    n_chk++; n_fail++;
    $display("FAIL global_timeout: got no end of test, expected finish before 50000 cycles");
    summary();
  end

  initial begin : main
    int cyc;
    nreset = 1'b0; start_i = 1'b0; kk_i = '0; nn_i = '0; ll_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_cmd_data", {cmd_o, data_o}, 0);
    chk("rst_m_ready", m_ready_o, 0);
    chk("rst_digest", {h_v_o, h_o, h_last_o}, 0);
    chk("rst_busy_err", {busy_o, err_o}, 0);
    nreset = 1'b1;
    @(negedge clk);

    prep(0, 0);
    msg_b.push_back(8'h61); msg_b.push_back(8'h62); msg_b.push_back(8'h63);
    run_msg(0, 32, 3, 0, 0, 1'b0);
    prep(0, 64);  run_msg(0, 32, 64, 0, 0, 1'b0);
    prep(0, 65);  run_msg(0, 16, 65, 0, 0, 1'b1);
    prep(4, 0);   run_msg(4, 16, 0, 0, 5, 1'b0);
    prep(0, 0);   run_msg(0, 1, 0, 0, 2, 1'b0);
    prep(0, 150); run_msg(0, 20, 150, 50, 0, 1'b0);
    prep(32, 70); run_msg(32, 32, 70, 50, 3, 1'b0);

    bad_cfg(0, 0);
    bad_cfg(33, 8);
    bad_cfg(3, 33);

    // Maximum length: configuration bytes only, then the host waits for upstream data.
    build_conf(0, 32, 64'hFFFF_FFFF_FFFF_FFFF);
    gap_pct = 0;
    @(negedge clk);
    start_i = 1'b1; kk_i = 6'd0; nn_i = 6'd32; ll_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    start_i = 1'b0;
    repeat (30) @(negedge clk);
    chk("huge_ll_conf_sent", exp_pin.size(), 0);
    chk("huge_ll_wants_data", m_ready_o, 1);
    do_reset();

    // Abort during the first block, then a clean run.
    prep(0, 100);
    gap_pct = 0; cur_nn = 8; cur_extra = 0; hash_done = 1'b0;
    build_model(0, 8, 100);
    @(negedge clk);
    start_i = 1'b1; kk_i = 6'd0; nn_i = 6'd8; ll_i = 64'd100;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (bcnt < 20 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    chk("reached_block_byte20", bcnt >= 20, 1);
    do_reset();
    prep(2, 20); run_msg(2, 12, 20, 0, 1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int kk, nn, ll, gp;
      kk = $urandom_range(32);
      nn = $urandom_range(32, 1);
      ll = $urandom_range(150);
      gp = $urandom_range(60);
      prep(kk, ll);
      run_msg(kk, nn, ll, gp, $urandom_range(3), 1'b0);
    end

    summary();
  end
endmodule
